instr_encoder: RTL
==================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 22, meaning the number of instruction-memory bytes; legal addresses are 0..MEM_DEPTH-1.
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of instr_count.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  instruction fields are valid.
REQ-006 in_ready  output  1  encoder can accept an instruction this cycle.
REQ-007 icode, ifun, rA, rB  input  4 each  fields of the instruction to encode.
REQ-008 valC  input  64  constant word.
REQ-009 pc_load  input  1  load pc_load_addr into next_pc.
REQ-010 pc_load_addr  input  64  new write base.
REQ-011 wr_en  output  1  instruction-memory byte write strobe.
REQ-012 wr_addr  output  64  byte address for the write.
REQ-013 wr_data  output  8  byte to write.
REQ-014 next_pc  output  64  address where the next instruction will start.
REQ-015 busy  output  1  high while bytes are being emitted.
REQ-016 stat  output  8  status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
REQ-017 instr_count  output  CNT_W  number of instructions completely written.

Function
REQ-018 States SHALL be IDLE, EMIT and ERR; in_ready SHALL be 1 only in IDLE with pc_load=0.
REQ-019 Accept SHALL occur when in_valid && in_ready; icode, ifun, rA, rB and valC are captured; later input changes are ignored until the next accept.
REQ-020 Length: icode 0, 1, 9 -> 1 byte; icode 2, 6, 10, 11 -> 2 bytes; icode 3, 4, 5, 7, 8 -> 10 bytes.
REQ-021 Byte order: byte0={icode,ifun}; byte1={rA,rB}; bytes 2..9 = valC[7:0] through valC[63:56], little-endian.
REQ-022 On accept of a legal, in-bounds instruction, the FSM SHALL go to EMIT; byte k SHALL be written on the (k+1)th cycle after accept, with wr_addr=next_pc+k, one byte per cycle, wr_en high for exactly len cycles.
REQ-023 In the cycle after the last byte, the block SHALL be in IDLE with next_pc=old next_pc+len and instr_count incremented by 1; instr_count wraps modulo 2^CNT_W.
REQ-024 busy SHALL equal (state==EMIT).
REQ-025 icode>11 at accept SHALL set stat=4, perform no write and go to ERR.
REQ-026 next_pc+len>MEM_DEPTH at accept SHALL set stat=3, perform no write and go to ERR; 64-bit arithmetic SHALL not wrap silently, and any overflow counts as out-of-bounds.
REQ-027 ERR SHALL hold stat, keep in_ready=0 and wr_en=0, and be left only by reset.
REQ-028 pc_load in IDLE SHALL set next_pc=pc_load_addr on the next edge and takes priority over a same-cycle in_valid, which is not accepted; pc_load outside IDLE SHALL be ignored.
REQ-029 wr_addr and wr_data SHALL be 0 whenever wr_en=0.

Reset
REQ-030 rst_n low SHALL immediately force state=IDLE, wr_en=0, wr_addr=0, wr_data=0, next_pc=0, busy=0, stat=1 and instr_count=0; a partially emitted instruction is abandoned and its written bytes are left in memory.
REQ-031 in_ready SHALL become 1 in the first cycle after rst_n deasserts.

Configuration
REQ-032 Macro ENC_HALT_STOP_EN:
- Defined: after the single byte of icode 0 is written, stat=2, and the block stays in a non-accepting state with in_ready=0 until reset.
- Undefined: icode 0 is an ordinary 1-byte instruction and stat stays 1.

Verification
REQ-033 Reset, accept icode=3 ifun=0 rA=F rB=2 valC=0x0000000000000005 -> bytes 30,F2,05,00,00,00,00,00,00,00 at addresses 0..9 over cycles 1..10, next_pc=10, instr_count=1.
REQ-034 Back-to-back icode=6/ifun=0/rA=0/rB=2 then icode=1 with in_valid held high -> 60,02 at addresses 0,1, then 10 at address 2, next_pc=3, instr_count=2, no accept while busy.
REQ-035 pc_load_addr=15 with in_valid high in the same cycle, then icode=3 -> no accept in the load cycle; icode=3 is then rejected (15+10>22), stat=3, no wr_en, in_ready stays 0.
REQ-036 icode=12 -> stat=4, no write; then a pulse of rst_n low -> stat=1, in_ready=1.
REQ-037 With ENC_HALT_STOP_EN, icode=0 at next_pc=4 -> write 00 at address 4, stat=2, in_ready=0; without the macro -> stat=1, in_ready=1, next_pc=5.
REQ-038 rst_n low during the 5th byte of an icode=4 emit -> wr_en drops to 0 asynchronously, next_pc=0, instr_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
// Y86-style instruction encoder: accepts one instruction, then writes its bytes to memory one per cycle.
// Optional macro ENC_HALT_STOP_EN: a written halt (icode 0) stops the block with stat=HLT until reset.
module instr_encoder #(
  parameter int MEM_DEPTH = 22,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic [63:0]      valC,
  input  logic             pc_load,
  input  logic [63:0]      pc_load_addr,
  output logic             wr_en,
  output logic [63:0]      wr_addr,
  output logic [7:0]       wr_data,
  output logic [63:0]      next_pc,
  output logic             busy,
  output logic [7:0]       stat,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_ERR} state_e;

  localparam logic [7:0] STAT_AOK = 8'd1;
  localparam logic [7:0] STAT_HLT = 8'd2;
  localparam logic [7:0] STAT_ADR = 8'd3;
  localparam logic [7:0] STAT_INS = 8'd4;

`ifdef ENC_HALT_STOP_EN
  localparam bit HALT_STOP_EN = 1'b1;
`else
  localparam bit HALT_STOP_EN = 1'b0;
`endif

  // Encoded length in bytes; 0 marks an illegal icode.
  function automatic logic [3:0] instr_len(input logic [3:0] code);
    case (code)
      4'h0, 4'h1, 4'h9:                   instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:             instr_len = 4'd2;
      4'h3, 4'h4, 4'h5, 4'h7, 4'h8:       instr_len = 4'd10;
      default:                            instr_len = 4'd0;
    endcase
  endfunction

  state_e           state_q;
  logic             wr_en_q;
  logic [63:0]      wr_addr_q;
  logic [7:0]       wr_data_q;
  logic [63:0]      next_pc_q;
  logic [7:0]       stat_q;
  logic [CNT_W-1:0] cnt_q;
  logic [71:0]      shift_q;
  logic [3:0]       len_q;
  logic [3:0]       idx_q;
  logic             halt_q;

  logic [3:0]  len_in;
  logic [64:0] end_addr_d;
  logic        out_of_bounds;
  logic        last_byte;
  logic [63:0] next_pc_d;

  // The bound check is done one bit wider so a wrapping 64-bit sum reads as out-of-bounds.
  assign len_in        = instr_len(icode);
  assign end_addr_d    = {1'b0, next_pc_q} + 65'(len_in);
  assign out_of_bounds = end_addr_d > 65'(MEM_DEPTH);
  assign last_byte     = (idx_q == len_q - 4'd1);
  assign next_pc_d     = next_pc_q + 64'(len_q);

  // NOTE: every register, including the byte shifter, is reset so outputs are defined the instant rst_n falls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      next_pc_q <= '0;
      stat_q    <= STAT_AOK;
      cnt_q     <= '0;
      shift_q   <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      halt_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      case (state_q)
        S_IDLE: begin
          if (pc_load) begin
            next_pc_q <= pc_load_addr;
          end else if (in_valid) begin
            if (len_in == 4'd0) begin
              stat_q  <= STAT_INS;
              state_q <= S_ERR;
            end else if (out_of_bounds) begin
              stat_q  <= STAT_ADR;
              state_q <= S_ERR;
            end else begin
              state_q   <= S_EMIT;
              wr_en_q   <= 1'b1;
              wr_addr_q <= next_pc_q;
              wr_data_q <= {icode, ifun};
              shift_q   <= {valC, rA, rB};
              len_q     <= len_in;
              idx_q     <= '0;
              halt_q    <= (icode == 4'h0);
            end
          end
        end
        S_EMIT: begin
          if (last_byte) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            next_pc_q <= next_pc_d;
            cnt_q     <= cnt_q + CNT_W'(1);
            if (HALT_STOP_EN && halt_q) begin
              stat_q  <= STAT_HLT;
              state_q <= S_ERR;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            idx_q     <= idx_q + 4'd1;
            wr_addr_q <= wr_addr_q + 64'd1;
            wr_data_q <= shift_q[7:0];
            shift_q   <= {8'h00, shift_q[71:8]};
          end
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !pc_load;
  assign busy        = (state_q == S_EMIT);
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign next_pc     = next_pc_q;
  assign stat        = stat_q;
  assign instr_count = cnt_q;

endmodule
